// File: rtl/adder_ring_measure_ctrl.sv
// Measurement sequencer for the instrumented ripple adder. It loads the operands, lets them settle,
// then opens the ring and counts synchronised chain_out rising edges over a programmed window.
module adder_ring_measure_ctrl #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_WIDTH     = 32,
   parameter int WIN_WIDTH     = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 active,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   input  logic [WIN_WIDTH-1:0] window,
   input  logic                 chain_out,
   output logic [WIDTH-1:0]     adder_a,
   output logic [WIDTH-1:0]     adder_b,
   output logic                 ring_en,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 overflow,
   output logic                 err
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [WIN_WIDTH-1:0] win_q, win_d, wcnt_q, wcnt_d;
   logic [SW-1:0]        settle_q, settle_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 ovf_q, ovf_d, err_q, err_d;
   logic                 sync1_q, sync2_q, sync3_q;
   logic                 edge_pulse;

   // chain_out is asynchronous: two flops for metastability, third for edge detection.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= chain_out;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign edge_pulse = sync2_q & ~sync3_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         win_q    <= '0;
         wcnt_q   <= '0;
         settle_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         win_q    <= win_d;
         wcnt_q   <= wcnt_d;
         settle_q <= settle_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      win_d    = win_q;
      wcnt_d   = wcnt_q;
      settle_d = settle_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      // Dropping active aborts to IDLE but leaves the last result visible.
      if (!active) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = S_LOAD;
                  a_d     = a_in;
                  b_d     = b_in;
                  win_d   = window;
                  count_d = '0;
                  ovf_d   = 1'b0;
                  err_d   = 1'b0;
               end
            end
            S_LOAD: begin
               if (win_q == '0) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  settle_d = SW'(SETTLE_CYCLES - 1);
                  state_d  = S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (settle_q == '0) begin
                  wcnt_d  = win_q - WIN_WIDTH'(1);
                  state_d = S_RUN;
               end else begin
                  settle_d = settle_q - SW'(1);
               end
            end
            S_RUN: begin
               if (edge_pulse) begin
                  if (&count_q) ovf_d = 1'b1;
                  else          count_d = count_q + CNT_WIDTH'(1);
               end
               if (wcnt_q == '0) state_d = S_DONE;
               else              wcnt_d = wcnt_q - WIN_WIDTH'(1);
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign adder_a  = a_q;
   assign adder_b  = b_q;
   assign ring_en  = (state_q == S_RUN);
   assign busy     = (state_q == S_LOAD) || (state_q == S_SETTLE) || (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign count    = count_q;
   assign overflow = ovf_q;
   assign err      = err_q;

endmodule

// File: tb/tb_adder_ring_measure_ctrl.sv
// Bench for adder_ring_measure_ctrl: a 32-bit and a 4-bit counter build share stimulus; expected
// counts come from the recorded chain_out samples and the measurement window timing.
module tb_adder_ring_measure_ctrl;
   localparam int S = 4;

   logic        clk = 1'b0, rst = 1'b0, active = 1'b0, start = 1'b0, chain_out = 1'b0;
   logic [31:0] a_in = '0, b_in = '0;
   logic [15:0] window = '0;

   logic [31:0] d32_a, d32_b, d32_count, d4_a, d4_b;
   logic [3:0]  d4_count;
   logic        d32_ring, d32_busy, d32_done, d32_ovf, d32_err;
   logic        d4_ring, d4_busy, d4_done, d4_ovf, d4_err;

   adder_ring_measure_ctrl #(.WIDTH(32), .SETTLE_CYCLES(S), .CNT_WIDTH(32), .WIN_WIDTH(16)) u_d32 (
      .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start), .a_in(a_in), .b_in(b_in),
      .window(window), .chain_out(chain_out), .adder_a(d32_a), .adder_b(d32_b), .ring_en(d32_ring),
      .busy(d32_busy), .done(d32_done), .count(d32_count), .overflow(d32_ovf), .err(d32_err));

   adder_ring_measure_ctrl #(.WIDTH(32), .SETTLE_CYCLES(S), .CNT_WIDTH(4), .WIN_WIDTH(16)) u_d4 (
      .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start), .a_in(a_in), .b_in(b_in),
      .window(window), .chain_out(chain_out), .adder_a(d4_a), .adder_b(d4_b), .ring_en(d4_ring),
      .busy(d4_busy), .done(d4_done), .count(d4_count), .overflow(d4_ovf), .err(d4_err));

   always #5 clk = ~clk;

   int          n_chk = 0, n_pass = 0;
   int          cyc = 0, t0 = 0, mode = 0;
   bit          force_v = 1'b0;
   bit          h [0:16383];
   int          ring_cnt, first_ring;
   logic        ld_busy, ld_done, p1_done;
   logic [31:0] ld_cnt, ld_a, ld_b;
   longint      e32, e4;
   bit          o32, o4;

   // chain_out value to be sampled at edge index s; patterns are relative to the first RUN cycle
   function automatic bit chain_val(int s);
      int rel;
      rel = s - (t0 + S + 2);
      case (mode)
         0:       return (rel >= 0) && ((rel / 4) % 2 == 0);
         1:       return (rel >= 0) && (rel % 2 == 0);
         2:       return 1'($urandom_range(0, 1));
         default: return force_v;
      endcase
   endfunction

   task automatic step();
      chain_out = chain_val(cyc);
      @(posedge clk);
      h[cyc] = rst ? 1'b0 : chain_out;
      cyc++;
      #1;
   endtask

   // A rising sample at edge k is counted at edge k+2 if that edge closes a RUN cycle.
   task automatic model(input int e_lo, input int e_hi, input int cw, output longint cnt, output bit ovf);
      longint n, mx;
      n  = 0;
      mx = (longint'(1) << cw) - 1;
      for (int e = e_lo; e <= e_hi; e++)
         if (e >= 3 && h[e-2] && !h[e-3]) n++;
      cnt = (n > mx) ? mx : n;
      ovf = (n > mx);
   endtask

   task automatic measure(input logic [31:0] a, input logic [31:0] b, input int w, input int md, input bit inj);
      a_in = a; b_in = b; window = 16'(w); mode = md;
      start = 1'b1; t0 = cyc;
      step();
      start = 1'b0;
      ld_busy = d32_busy; ld_done = d32_done; ld_cnt = d32_count; ld_a = d32_a; ld_b = d32_b;
      if (inj) begin a_in = ~a; b_in = ~b; window = 16'(w + 7); end
      ring_cnt = 0; first_ring = -1;
      for (int i = 0; i < S + w + 3; i++) begin
         start = inj && (i == 2 || i == S + 3 || i == S + 5);
         step();
         if (i == 0) p1_done = d32_done;
         if (d32_ring === 1'b1) begin
            ring_cnt++;
            if (first_ring < 0) first_ring = cyc - 1 - t0;
         end
      end
      start = 1'b0;
      model(t0 + S + 2, t0 + S + 1 + w, 32, e32, o32);
      model(t0 + S + 2, t0 + S + 1 + w, 4, e4, o4);
   endtask

   task automatic test_reset();
      active = 1'b1; rst = 1'b1; start = 1'b1; a_in = 32'hDEAD_BEEF; window = 16'd5;
      step(); start = 1'b0; step(); rst = 1'b0;
      n_chk++; if (d32_busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", d32_busy); else n_pass++;
      n_chk++; if (d32_done !== 1'b0) $display("FAIL reset_done got %0b exp 0", d32_done); else n_pass++;
      n_chk++; if (d32_ring !== 1'b0) $display("FAIL reset_ring got %0b exp 0", d32_ring); else n_pass++;
      n_chk++; if ({d32_a, d32_b} !== 64'd0) $display("FAIL reset_ops got %0h exp 0", {d32_a, d32_b}); else n_pass++;
      n_chk++; if (d32_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", d32_count); else n_pass++;
      n_chk++; if ({d32_ovf, d32_err} !== 2'b00) $display("FAIL reset_flags got %0b exp 0", {d32_ovf, d32_err}); else n_pass++;
      n_chk++; if ({d4_count, d4_ovf} !== 5'd0) $display("FAIL reset_d4 got %0h exp 0", {d4_count, d4_ovf}); else n_pass++;
   endtask

   task automatic test_normal();
      measure(32'h0000_000F, 32'h0000_0001, 64, 0, 1'b0);
      n_chk++; if (ld_a !== 32'hF || ld_b !== 32'h1) $display("FAIL normal_load_ops got %0h/%0h exp f/1", ld_a, ld_b); else n_pass++;
      n_chk++; if (ld_busy !== 1'b1) $display("FAIL normal_load_busy got %0b exp 1", ld_busy); else n_pass++;
      n_chk++; if (ring_cnt !== 64) $display("FAIL normal_ring_len got %0d exp 64", ring_cnt); else n_pass++;
      n_chk++; if (first_ring !== S + 1) $display("FAIL normal_ring_start got %0d exp %0d", first_ring, S + 1); else n_pass++;
      n_chk++; if (d32_count !== 32'(e32)) $display("FAIL normal_count got %0d exp %0d", d32_count, e32); else n_pass++;
      n_chk++; if (d32_count !== 32'd8) $display("FAIL normal_count8 got %0d exp 8", d32_count); else n_pass++;
      n_chk++; if ({d32_done, d32_ovf, d32_err} !== 3'b100) $display("FAIL normal_flags got %0b exp 100", {d32_done, d32_ovf, d32_err}); else n_pass++;
      n_chk++; if (d4_count !== 4'(e4)) $display("FAIL normal_d4_count got %0d exp %0d", d4_count, e4); else n_pass++;
   endtask

   task automatic test_zero_window();
      measure($urandom, $urandom, 0, 2, 1'b0);
      n_chk++; if (ld_busy !== 1'b1) $display("FAIL zero_load_busy got %0b exp 1", ld_busy); else n_pass++;
      n_chk++; if (p1_done !== 1'b1) $display("FAIL zero_done_time got %0b exp 1", p1_done); else n_pass++;
      n_chk++; if (ring_cnt !== 0) $display("FAIL zero_ring got %0d exp 0", ring_cnt); else n_pass++;
      n_chk++; if ({d32_done, d32_err} !== 2'b11) $display("FAIL zero_flags got %0b exp 11", {d32_done, d32_err}); else n_pass++;
      n_chk++; if (d32_count !== 32'd0) $display("FAIL zero_count got %0d exp 0", d32_count); else n_pass++;
   endtask

   task automatic test_saturation();
      measure($urandom, $urandom, 100, 1, 1'b0);
      n_chk++; if (d4_count !== 4'hF) $display("FAIL sat_d4_count got %0d exp 15", d4_count); else n_pass++;
      n_chk++; if (d4_ovf !== 1'b1) $display("FAIL sat_d4_ovf got %0b exp 1", d4_ovf); else n_pass++;
      n_chk++; if (d32_count !== 32'(e32) || d32_ovf !== 1'b0) $display("FAIL sat_d32 got %0d/%0b exp %0d/0", d32_count, d32_ovf, e32); else n_pass++;
   endtask

   task automatic test_ignored_starts();
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      measure(a, b, 20, 2, 1'b1);
      n_chk++; if (ring_cnt !== 20) $display("FAIL ign_ring_len got %0d exp 20", ring_cnt); else n_pass++;
      n_chk++; if (d32_count !== 32'(e32)) $display("FAIL ign_count got %0d exp %0d", d32_count, e32); else n_pass++;
      n_chk++; if (d32_a !== a || d32_b !== b) $display("FAIL ign_ops got %0h/%0h exp %0h/%0h", d32_a, d32_b, a, b); else n_pass++;
      n_chk++; if (d32_done !== 1'b1) $display("FAIL ign_done got %0b exp 1", d32_done); else n_pass++;
   endtask

   task automatic test_restart_from_done();
      logic [31:0] a;
      a = $urandom;
      measure(a, 32'h1234_5678, 12, 2, 1'b0);
      n_chk++; if ({ld_busy, ld_done} !== 2'b10) $display("FAIL restart_state got %0b exp 10", {ld_busy, ld_done}); else n_pass++;
      n_chk++; if (ld_cnt !== 32'd0) $display("FAIL restart_clear got %0d exp 0", ld_cnt); else n_pass++;
      n_chk++; if (ld_a !== a) $display("FAIL restart_ops got %0h exp %0h", ld_a, a); else n_pass++;
      n_chk++; if (d32_count !== 32'(e32)) $display("FAIL restart_count got %0d exp %0d", d32_count, e32); else n_pass++;
   endtask

   task automatic test_abort();
      logic [31:0] held;
      a_in = 32'hA5A5_0001; b_in = 32'h5A5A_0002; window = 16'd40; mode = 2;
      start = 1'b1; t0 = cyc; step(); start = 1'b0;
      for (int i = 0; i < S + 10; i++) step();
      n_chk++; if (d32_ring !== 1'b1) $display("FAIL abort_in_run got %0b exp 1", d32_ring); else n_pass++;
      active = 1'b0; step();
      model(t0 + S + 2, t0 + S + 10, 32, e32, o32);
      n_chk++; if ({d32_ring, d32_busy, d32_done} !== 3'b000) $display("FAIL abort_idle got %0b exp 000", {d32_ring, d32_busy, d32_done}); else n_pass++;
      n_chk++; if (d32_count !== 32'(e32)) $display("FAIL abort_partial got %0d exp %0d", d32_count, e32); else n_pass++;
      held = d32_count;
      a_in = 32'h0BAD_0BAD; start = 1'b1; step(); start = 1'b0; step(); step();
      n_chk++; if ({d32_busy, d32_done} !== 2'b00) $display("FAIL abort_start_ign got %0b exp 00", {d32_busy, d32_done}); else n_pass++;
      n_chk++; if (d32_count !== held || d32_a !== 32'hA5A5_0001) $display("FAIL abort_hold got %0d/%0h exp %0d/a5a50001", d32_count, d32_a, held); else n_pass++;
      active = 1'b1; step();
   endtask

   task automatic test_reset_mid_run();
      mode = 3; force_v = 1'b0;
      a_in = $urandom; b_in = $urandom; window = 16'd40;
      start = 1'b1; t0 = cyc; step(); start = 1'b0;
      for (int i = 0; i < S + 6; i++) step();
      force_v = 1'b1; step();
      rst = 1'b1; step(); rst = 1'b0;
      n_chk++; if ({d32_a, d32_b} !== 64'd0) $display("FAIL rstrun_ops got %0h exp 0", {d32_a, d32_b}); else n_pass++;
      n_chk++; if ({d32_ring, d32_busy, d32_done, d32_ovf, d32_err} !== 5'd0) $display("FAIL rstrun_flags got %0b exp 0", {d32_ring, d32_busy, d32_done, d32_ovf, d32_err}); else n_pass++;
      for (int i = 0; i < 5; i++) step();
      n_chk++; if (d32_count !== 32'd0 || d32_busy !== 1'b0) $display("FAIL rstrun_after got %0d/%0b exp 0/0", d32_count, d32_busy); else n_pass++;
      force_v = 1'b0; step();
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      int w;
      for (int k = 0; k < 6; k++) begin
         a = $urandom; b = $urandom; w = $urandom_range(1, 30);
         measure(a, b, w, 2, 1'b0);
         n_chk++; if (ring_cnt !== w) $display("FAIL rand_ring[%0d] got %0d exp %0d", k, ring_cnt, w); else n_pass++;
         n_chk++; if (d32_count !== 32'(e32) || d32_ovf !== o32) $display("FAIL rand_c32[%0d] got %0d/%0b exp %0d/%0b", k, d32_count, d32_ovf, e32, o32); else n_pass++;
         n_chk++; if (d4_count !== 4'(e4) || d4_ovf !== o4) $display("FAIL rand_c4[%0d] got %0d/%0b exp %0d/%0b", k, d4_count, d4_ovf, e4, o4); else n_pass++;
         n_chk++; if (d32_a !== a || d32_b !== b || d32_done !== 1'b1) $display("FAIL rand_ops[%0d] got %0h/%0h/%0b exp %0h/%0h/1", k, d32_a, d32_b, d32_done, a, b); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_zero_window();
      test_saturation();
      test_ignored_starts();
      test_restart_from_done();
      test_abort();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
